// File: rtl/apb_mem_responder.sv
// apb_mem_responder: word-addressed memory responder with programmable wait states and byte strobes
// Ports:
//   clk    rising-edge clock
//   rts_n  synchronous active-low reset
//   addr   word address, bits [AW-1:0] index memory
//   wdata  write data
//   rdata  read data, lanes with strb[i]=0 forced to zero
//   sel    transfer select (setup and access phases)
//   en     access phase enable
//   wr     1 = write, 0 = read
//   strb   byte-lane enables
//   ready  one-cycle completion pulse
//   err    error response, only when APB_ERR_EN is defined
// Optional feature macro: APB_ERR_EN (upper address bits nonzero -> error response, no access)
module apb_mem_responder #(
    parameter int AW   = 10,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rts_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        sel,
    input  logic        en,
    input  logic        wr,
    input  logic [3:0]  strb,
    output logic        ready
`ifdef APB_ERR_EN
    ,
    output logic        err
`endif
);
    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;
    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic           r_wr;
    logic [3:0]     r_strb;
    logic           r_ready;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [2**AW];
    logic [31:0]    w_mask;
    logic           w_fire;
    logic           w_we;
    logic           w_bad;
`ifdef APB_ERR_EN
    logic           r_bad;
    logic           r_err;
    assign w_bad = r_bad;
    assign err   = r_err;
`else
    // upper address bits only alias onto the same words
    logic           w_unused_addr;
    assign w_unused_addr = |addr[31:AW];
    assign w_bad = 1'b0;
`endif
    assign ready  = r_ready;
    assign rdata  = r_rdata;
    assign w_mask = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};
    // the access happens on the edge that finds the wait count exhausted with the bus still in access
    assign w_fire = (r_state == WAITING) && sel && en && (r_cnt == 4'd0);
    assign w_we   = rts_n && w_fire && r_wr && !w_bad;
    // kept free of reset so it maps onto byte-enabled block RAM
    always_ff @(posedge clk) begin
        if (w_we)
            for (int i = 0; i < 4; i++)
                if (r_strb[i]) r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (!rts_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_cnt   <= 4'd0;
`ifdef APB_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (sel && en) begin
                        r_addr  <= addr[AW-1:0];
                        r_wdata <= wdata;
                        r_wr    <= wr;
                        r_strb  <= strb;
                        r_cnt   <= 4'(WAIT);
`ifdef APB_ERR_EN
                        r_bad   <= |addr[31:AW];
`endif
                        r_state <= WAITING;
                    end
                end
                WAITING: begin
                    if (!(sel && en))
                        r_state <= IDLE;
                    else if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else begin
                        r_ready <= 1'b1;
                        r_state <= RESP;
`ifdef APB_ERR_EN
                        r_err   <= w_bad;
`endif
                        if (w_bad)
                            r_rdata <= 32'd0;
                        else if (!r_wr)
                            r_rdata <= r_mem[r_addr] & w_mask;
                    end
                end
                RESP: begin
                    r_ready <= 1'b0;
`ifdef APB_ERR_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_responder.sv
// tb_apb_mem_responder: table, hand-written and random checks of apb_mem_responder against a memory model
module tb_apb_mem_responder;
    localparam int AW   = 10;
    localparam int WAIT = 2;
`ifdef APB_ERR_EN
    localparam logic [31:0] ALIAS_EXP = 32'h0;
`else
    localparam logic [31:0] ALIAS_EXP = 32'hDEADBEEF;
`endif
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;
    logic        clk = 1'b0;
    logic        rts_n = 1'b0;
    logic        sel = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  strb = 4'd0;
    logic [31:0] rdata;
    logic        ready;
`ifdef APB_ERR_EN
    logic        err;
`endif
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [int];
    logic [31:0] last_rd = 32'd0;
    vec_t        tab [17];

    always #5 clk = ~clk;

    apb_mem_responder #(.AW(AW), .WAIT(WAIT)) dut (
        .clk(clk),
        .rts_n(rts_n),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .sel(sel),
        .en(en),
        .wr(wr),
        .strb(strb),
        .ready(ready)
`ifdef APB_ERR_EN
        ,
        .err(err)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m = 32'd0;
        for (int i = 0; i < 4; i++)
            if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full transfer: setup, access, wait for ready, compare with the model, release the bus
    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        int          lat = 0;
        int          k;
        logic        bad = 1'b0;
        logic [31:0] m;
`ifdef APB_ERR_EN
        bad = (a >> AW) != 0;
`endif
        k = int'(a % (1 << AW));
        m = lane_mask(s);
        sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d; strb = s;
        tick();
        check("setup_no_ready", 32'(ready), 32'd0);
        en = 1'b1;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(WAIT + 2));
        if (bad)
            last_rd = 32'd0;
        else if (w)
            mem_m[k] = ((mem_m.exists(k) ? mem_m[k] : 32'd0) & ~m) | (d & m);
        else if (mem_m.exists(k))
            last_rd = mem_m[k] & m;
        else
            check("model_has_addr", 32'(k), 32'hFFFFFFFF);
        check("rdata", rdata, last_rd);
`ifdef APB_ERR_EN
        check("err_resp", 32'(err), 32'(bad));
`endif
        rd = rdata;
        sel = 1'b0; en = 1'b0;
        tick();
        check("ready_one_cycle", 32'(ready), 32'd0);
`ifdef APB_ERR_EN
        check("err_one_cycle", 32'(err), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old;
        int          lat;
        tab = '{
            '{1'b1, 32'd5,     32'hDEADBEEF, 4'hF, 32'h0},
            '{1'b0, 32'd5,     32'h0,        4'hF, 32'hDEADBEEF},
            '{1'b1, 32'd7,     32'h11223344, 4'hF, 32'h0},
            '{1'b1, 32'd7,     32'h000000AA, 4'h1, 32'h0},
            '{1'b0, 32'd7,     32'h0,        4'h3, 32'h000033AA},
            '{1'b0, 32'd7,     32'h0,        4'h1, 32'h000000AA},
            '{1'b0, 32'd7,     32'h0,        4'hF, 32'h112233AA},
            '{1'b1, 32'd5,     32'h12345678, 4'h0, 32'h0},
            '{1'b0, 32'd5,     32'h0,        4'hF, 32'hDEADBEEF},
            '{1'b0, 32'd5,     32'h0,        4'h0, 32'h0},
            '{1'b1, 32'd1,     32'hA5A5A5A5, 4'hF, 32'h0},
            '{1'b1, 32'd2,     32'h5A5A5A5A, 4'hF, 32'h0},
            '{1'b1, 32'd3,     32'hC3C3C3C3, 4'hF, 32'h0},
            '{1'b1, 32'd9,     32'hCAFEF00D, 4'hF, 32'h0},
            '{1'b0, 32'h405,   32'h0,        4'hF, ALIAS_EXP},
            '{1'b1, 32'd7,     32'h77000000, 4'h8, 32'h0},
            '{1'b0, 32'd7,     32'h0,        4'hF, 32'h772233AA}
        };
        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rts_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 32'(ready), 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end
        // directed vectors
        for (int i = 0; i < 17; i++) begin
            run(tab[i].w, tab[i].a, tab[i].d, tab[i].s, rd);
            if (!tab[i].w) check("vec_rdata", rd, tab[i].exp);
        end
        // abort after one wait cycle: no ready, no write
        old = mem_m[9];
        sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 32'd9; wdata = 32'h0BADBAD0; strb = 4'hF;
        tick();
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_ready", 32'(ready), 32'd0);
        end
        sel = 1'b0;
        tick();
        run(1'b0, 32'd9, 32'd0, 4'hF, rd);
        check("abort_mem_kept", rd, old);
        // back-to-back reads with sel&en held
        sel = 1'b1; en = 1'b0; wr = 1'b0; addr = 32'd1; strb = 4'hF;
        tick();
        en = 1'b1;
        lat = 0;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_lat0", 32'(lat), 32'(WAIT + 2));
        check("b2b_rdata0", rdata, 32'hA5A5A5A5);
        addr = 32'd2;
        tick();
        check("b2b_idle_gap", 32'(ready), 32'd0);
        lat = 1;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_lat1", 32'(lat), 32'(WAIT + 3));
        check("b2b_rdata1", rdata, 32'h5A5A5A5A);
        last_rd = 32'h5A5A5A5A;
        sel = 1'b0; en = 1'b0;
        tick();
        check("b2b_ready_drop", 32'(ready), 32'd0);
        // reset while waiting drops the write
        sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 32'd3; wdata = 32'h55AA55AA; strb = 4'hF;
        tick();
        en = 1'b1;
        tick();
        tick();
        rts_n = 1'b0; sel = 1'b0; en = 1'b0;
        tick();
        check("rst_wait_ready", 32'(ready), 32'd0);
        check("rst_wait_rdata", rdata, 32'd0);
        last_rd = 32'd0;
        rts_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_wait_idle", 32'(ready), 32'd0);
        end
        run(1'b0, 32'd3, 32'd0, 4'hF, rd);
        check("rst_wait_mem_kept", rd, 32'hC3C3C3C3);
        // random traffic against the model
        for (int i = 0; i < 16; i++) run(1'b1, 32'(i), $urandom, 4'hF, rd);
`ifdef APB_ERR_EN
        old = mem_m[0];
        run(1'b0, 32'h400, 32'd0, 4'hF, rd);
        check("err_read_rdata", rd, 32'd0);
        run(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd);
        run(1'b0, 32'd0, 32'd0, 4'hF, rd);
        check("err_mem0_kept", rd, old);
`endif
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << AW);
            run(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_mem_responder.md
Name: apb_mem_responder

Overview:
- Word-addressed memory responder on the core's sel/en/wr/strobe/ready bus.
- Services instruction fetches and LOAD/STORE data accesses from the program-counter initiator.
- Inserts a programmable number of wait states and applies per-byte strobes on writes and reads.
- Sits between the core's bus initiator and on-chip storage.

Parameters:
- AW, 10: word-address width; memory depth is 2**AW 32-bit words.
- WAIT, 2: wait cycles inserted before ready; range 0..15.

Ports:
- clk  input  1: rising-edge clock.
- rts_n  input  1: reset, synchronous, active-low.
- addr  input  32: word address; bits [AW-1:0] index memory.
- wdata  input  32: write data.
- rdata  output  32: read data, lane-masked by strb.
- sel  input  1: transfer select, high through setup and access.
- en  input  1: access phase, set one cycle after sel.
- wr  input  1: 1 = write, 0 = read.
- strb  input  4: byte lanes; 0001 = byte, 0011 = half, 1111 = word.
- ready  output  1: transfer completes in the cycle sel&en&ready.
- err  output  1: present only with APB_ERR_EN; see Optional Feature.

Behaviour:
- Reset: state=IDLE, ready=0, rdata=0, cnt=0, err=0. Memory contents are not cleared.
- Reset mid-transfer drops the transfer; no write occurs.
- States: IDLE, WAITING, RESP.
- IDLE:
  - ready=0.
  - On an edge sampling sel=1, en=1: latch addr, wdata, wr, strb; cnt<=WAIT; go to WAITING.
  - sel=1, en=0 (setup phase) is ignored.
- WAITING:
  - If sel=0 or en=0: abort to IDLE; no memory write; rdata unchanged.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else (cnt==0): perform the access and set ready<=1; go to RESP.
    - Write: only lanes with strb[i]=1 are updated (bits 8i+7:8i); rdata unchanged.
    - Read: rdata<=mem word with lanes where strb[i]=0 forced to 0.
- RESP:
  - ready=1 for exactly one cycle.
  - Next edge: ready<=0, go to IDLE. Inputs are not sampled for a new transfer on that edge.
- Latency: the first access-phase edge is E0; ready is high in the cycle after edge E(WAIT+1).
  - Access-phase length = WAIT+2 cycles.
  - WAIT=0 gives 2 cycles.
- Back-to-back: the initiator may hold sel&en high after completion. The next transfer starts on the first IDLE edge that samples sel&en.
- Latched request fields are used for the access. Changes on addr, wdata, or strb during WAITING have no effect.
- strb=0000 write: no lanes change; still completes with ready.
- strb=0000 read: rdata<=0.
- rdata holds its value until the next read completion.
- Address bits [31:AW] are ignored; addresses alias modulo 2**AW.
- Writes and reads are never simultaneous (single port). Memory is synchronous and inferable as block RAM with byte enables.

Optional Feature:
- Macro: APB_ERR_EN.
- Defined:
  - err port exists.
  - If latched addr[31:AW] != 0, the RESP cycle has ready=1, err=1, no write, rdata<=0.
  - err is 0 in every other cycle.
- Undefined:
  - err port absent.
  - Upper address bits ignored (aliasing as above); no error path logic.

Test Plan:
1. Reset then idle, WAIT=2: hold rts_n=0 for 2 cycles, release, sel=en=0 -> ready=0, rdata=0, memory unchanged.
2. Word write/read: write addr=5, wdata=0xDEADBEEF, strb=1111 -> ready high exactly 1 cycle, 4 cycles after en rose. Read addr=5, strb=1111 -> rdata=0xDEADBEEF with ready.
3. Byte/half strobes: mem[7]=0x11223344.
   - Write wdata=0x000000AA, strb=0001 -> mem[7]=0x112233AA.
   - Read strb=0011 -> rdata=0x000033AA.
   - Read strb=0001 -> rdata=0x000000AA.
4. Abort: write starts to addr=9, en dropped after 1 wait cycle -> no ready, state IDLE, mem[9] unchanged. A subsequent full read of addr 9 returns the old value.
5. Back-to-back and WAIT=0 build: two consecutive reads of addr 1 and 2 with sel&en held -> each completes with ready after 2 access cycles, one IDLE cycle between them, and rdata matches each word. Reset asserted in WAITING -> ready stays 0 and the write is dropped.
6. APB_ERR_EN, AW=10: read addr=0x00000400 -> ready=1, err=1, rdata=0. Write to the same address leaves mem[0] unchanged. Next legal access -> err=0.
